// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
// Memory-mapped multi-digit seven-segment display controller. The CPU writes
// one hex nibble per digit plus decimal-point, blank and control registers
// over an Avalon-MM slave port. The digits are time-multiplexed onto one
// shared segment bus with a one-hot digit enable. The block also provides
// leading-zero suppression and whole-display blinking.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   address     register select (0 DATA, 1 DP, 2 BLANK, 3 CTRL)
//   chipselect  slave select
//   write       write strobe, qualified by chipselect
//   writedata   write data
//   readdata    combinational read of the selected register
//   segs        segment bus, segs[0]=a .. segs[6]=g (registered)
//   dp          decimal point (registered)
//   digit_en    one-hot digit enable, always active-high (registered)
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 25000000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [6:0]            segs,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] digit_en
);

    localparam int DATA_W  = 4 * NUM_DIGITS;
    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [2:0]         LAST_IDX   = 3'(NUM_DIGITS - 1);
    localparam logic [6:0]         SEGS_DARK  = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic               DP_DARK    = ACTIVE_LOW;

    // Registers
    logic [DATA_W-1:0]     r_data;
    logic [NUM_DIGITS-1:0] r_dp_bits;
    logic [NUM_DIGITS-1:0] r_blank;
    logic                  r_enable;
    logic                  r_lzs;
    logic                  r_blink;

    // Counters
    logic [SCAN_W-1:0]     r_scan_cnt;
    logic [2:0]            r_scan_idx;
    logic [BLINK_W-1:0]    r_blink_cnt;
    logic                  r_phase;

    // Output registers
    logic [6:0]            r_segs;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_digit_en;

    logic                  w_wr_en;
    logic [3:0]            w_nibble;
    logic                  w_dp_sel;
    logic                  w_blank_sel;
    logic                  w_upper_nz;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic                  w_dark;
    logic [6:0]            w_segs_on;
    logic                  w_dp_on;
    logic                  w_unused;

    // Writedata bits above the implemented register widths are ignored.
    assign w_unused = &{1'b0, writedata};

    function automatic logic [6:0] hex_to_segs(input logic [3:0] v);
        case (v)
            4'h0:    hex_to_segs = 7'h3F;
            4'h1:    hex_to_segs = 7'h06;
            4'h2:    hex_to_segs = 7'h5B;
            4'h3:    hex_to_segs = 7'h4F;
            4'h4:    hex_to_segs = 7'h66;
            4'h5:    hex_to_segs = 7'h6D;
            4'h6:    hex_to_segs = 7'h7D;
            4'h7:    hex_to_segs = 7'h07;
            4'h8:    hex_to_segs = 7'h7F;
            4'h9:    hex_to_segs = 7'h6F;
            4'hA:    hex_to_segs = 7'h77;
            4'hB:    hex_to_segs = 7'h7C;
            4'hC:    hex_to_segs = 7'h39;
            4'hD:    hex_to_segs = 7'h5E;
            4'hE:    hex_to_segs = 7'h79;
            default: hex_to_segs = 7'h71;
        endcase
    endfunction

    assign w_wr_en = chipselect & write;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data    <= '0;
            r_dp_bits <= '0;
            r_blank   <= '0;
            r_enable  <= 1'b1;
            r_lzs     <= 1'b0;
            r_blink   <= 1'b0;
        end else if (w_wr_en) begin
            case (address)
                2'd0: r_data    <= writedata[DATA_W-1:0];
                2'd1: r_dp_bits <= writedata[NUM_DIGITS-1:0];
                2'd2: r_blank   <= writedata[NUM_DIGITS-1:0];
                default: begin
                    r_enable <= writedata[0];
                    r_lzs    <= writedata[1];
                    r_blink  <= writedata[2];
                end
            endcase
        end
    end

    // Scan and blink timebases run regardless of ENABLE/BLINK so that the
    // digit cadence and blink phase never jump when those bits are toggled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_scan_idx <= (r_scan_idx == LAST_IDX) ? 3'd0 : r_scan_idx + 3'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata[DATA_W-1:0]     = r_data;
            2'd1: readdata[NUM_DIGITS-1:0] = r_dp_bits;
            2'd2: readdata[NUM_DIGITS-1:0] = r_blank;
            default: begin
                readdata[0]    = r_enable;
                readdata[1]    = r_lzs;
                readdata[2]    = r_blink;
                readdata[10:8] = r_scan_idx;
                readdata[16]   = r_phase;
            end
        endcase
    end

    // Select the current digit's fields; w_upper_nz flags any non-zero
    // nibble at or above the current index, which defeats suppression.
    always_comb begin
        w_nibble    = '0;
        w_dp_sel    = 1'b0;
        w_blank_sel = 1'b0;
        w_upper_nz  = 1'b0;
        w_onehot    = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (r_scan_idx == 3'(i)) begin
                w_nibble    = r_data[4*i +: 4];
                w_dp_sel    = r_dp_bits[i];
                w_blank_sel = r_blank[i];
                w_onehot[i] = 1'b1;
            end
            if ((32'(r_scan_idx) <= i) && (r_data[4*i +: 4] != 4'h0)) begin
                w_upper_nz = 1'b1;
            end
        end
        w_dark = !r_enable || w_blank_sel || (r_blink && r_phase) ||
                 (r_lzs && (r_scan_idx != 3'd0) && !w_upper_nz);
        w_segs_on = w_dark ? 7'h00 : hex_to_segs(w_nibble);
        w_dp_on   = !w_dark && w_dp_sel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_segs     <= SEGS_DARK;
            r_dp       <= DP_DARK;
            r_digit_en <= '0;
        end else begin
            r_segs     <= ACTIVE_LOW ? ~w_segs_on : w_segs_on;
            r_dp       <= ACTIVE_LOW ? ~w_dp_on : w_dp_on;
            r_digit_en <= r_enable ? w_onehot : '0;
        end
    end

    assign segs     = r_segs;
    assign dp       = r_dp;
    assign digit_en = r_digit_en;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Testbench for seven_seg_scan_ctrl (NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=64,
// ACTIVE_LOW=1). A cycle-count based reference model predicts every output.
module tb_seven_seg_scan_ctrl;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int BD = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [6:0]  segs;
    logic        dp;
    logic [N-1:0] digit_en;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS(N),
        .SCAN_DIV(SD),
        .BLINK_DIV(BD),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write(write),
        .writedata(writedata),
        .readdata(readdata),
        .segs(segs),
        .dp(dp),
        .digit_en(digit_en)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: register contents plus cycles elapsed since reset.
    logic [15:0] m_data;
    logic [3:0]  m_dp;
    logic [3:0]  m_blank;
    bit          m_en, m_lzs, m_blink;
    int          m_cycles;

    logic [6:0] enc_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        logic [3:0] val;
        logic [6:0] segs;
    } dec_vec_t;

    typedef struct {
        bit          cs;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] mask;
        logic [31:0] rexp;
    } reg_vec_t;

    dec_vec_t dec_tab [16];
    reg_vec_t reg_tab [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_idx();
        return (m_cycles / SD) % N;
    endfunction

    function automatic int m_phase();
        return (m_cycles / BD) % 2;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0: return {16'h0, m_data};
            2'd1: return {28'h0, m_dp};
            2'd2: return {28'h0, m_blank};
            default: return (32'(m_phase()) << 16) | (32'(m_idx()) << 8) |
                            {29'h0, m_blink, m_lzs, m_en};
        endcase
    endfunction

    task automatic model_reset();
        m_data = '0; m_dp = '0; m_blank = '0;
        m_en = 1'b1; m_lzs = 1'b0; m_blink = 1'b0;
        m_cycles = 0;
    endtask

    // One clock edge: predict outputs from pre-edge state, advance the
    // model with the inputs the DUT sees, then compare just after the edge.
    task automatic tick();
        logic [3:0] e_en;
        logic [6:0] e_sg;
        logic       e_dp;
        int         ix;
        bit         dark;
        if (reset) begin
            e_en = 4'h0; e_sg = 7'h7F; e_dp = 1'b1;
        end else begin
            ix = m_idx();
            dark = !m_en || m_blank[ix] || (m_blink && m_phase() == 1) ||
                   (m_lzs && ix != 0 && (m_data >> (4 * ix)) == 16'h0);
            e_en = m_en ? 4'(1 << ix) : 4'h0;
            e_sg = dark ? 7'h7F : ~enc_tab[m_data[4*ix +: 4]];
            e_dp = dark ? 1'b1 : !m_dp[ix];
        end
        if (reset) begin
            model_reset();
        end else begin
            if (chipselect && write) begin
                case (address)
                    2'd0: m_data  = writedata[15:0];
                    2'd1: m_dp    = writedata[3:0];
                    2'd2: m_blank = writedata[3:0];
                    default: begin
                        m_en = writedata[0]; m_lzs = writedata[1]; m_blink = writedata[2];
                    end
                endcase
            end
            m_cycles++;
        end
        @(posedge clk);
        #1;
        chk("model_digit_en", 32'(digit_en), 32'(e_en));
        chk("model_segs", 32'(segs), 32'(e_sg));
        chk("model_dp", 32'(dp), 32'(e_dp));
    endtask

    task automatic wr_cs(input bit cs, input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = cs; write = 1'b1;
        tick();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        wr_cs(1'b1, a, d);
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a,
                          input logic [31:0] mask, input logic [31:0] exp);
        address = a;
        #1;
        chk(name, readdata & mask, exp & mask);
    endtask

    // Wait for the first cycle of digit d being enabled (bounded).
    task automatic wait_digit(input int d);
        logic [3:0] prev;
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            prev = digit_en;
            tick();
            if (digit_en == 4'(1 << d) && prev != 4'(1 << d)) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_digit", 32'(ok), 32'd1);
    endtask

    initial begin
        logic [6:0] scan_exp [4];
        int         k;
        int         a0;
        bit         found;
        logic [31:0] d;

        scan_exp = '{7'h19, 7'h30, 7'h24, 7'h79};
        dec_tab = '{'{4'h0, 7'h40}, '{4'h1, 7'h79}, '{4'h2, 7'h24}, '{4'h3, 7'h30},
                    '{4'h4, 7'h19}, '{4'h5, 7'h12}, '{4'h6, 7'h02}, '{4'h7, 7'h78},
                    '{4'h8, 7'h00}, '{4'h9, 7'h10}, '{4'hA, 7'h08}, '{4'hB, 7'h03},
                    '{4'hC, 7'h46}, '{4'hD, 7'h21}, '{4'hE, 7'h06}, '{4'hF, 7'h0E}};
        reg_tab = '{'{1'b1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF},
                    '{1'b0, 2'd0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_FFFF},
                    '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_000F},
                    '{1'b1, 2'd2, 32'h0000_00A5, 32'hFFFF_FFFF, 32'h0000_0005},
                    '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'hFFFE_F8FF, 32'h0000_0007},
                    '{1'b1, 2'd3, 32'hFFFF_FFFA, 32'hFFFE_F8FF, 32'h0000_0002},
                    '{1'b0, 2'd3, 32'h0000_0001, 32'hFFFE_F8FF, 32'h0000_0002},
                    '{1'b1, 2'd3, 32'h0000_0001, 32'hFFFE_F8FF, 32'h0000_0001},
                    '{1'b1, 2'd0, 32'h1234_ABCD, 32'hFFFF_FFFF, 32'h0000_ABCD},
                    '{1'b1, 2'd1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
                    '{1'b1, 2'd2, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
                    '{1'b1, 2'd0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000}};
        model_reset();

        // Reset
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("rst_digit_en", 32'(digit_en), 32'h0);
        chk("rst_segs", 32'(segs), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        reset = 1'b0;
        tick();
        chk("first_digit_en", 32'(digit_en), 32'h1);
        chk("first_segs", 32'(segs), 32'h40);
        rd_chk("ctrl_after_reset", 2'd3, 32'hFFFF_FFFF, 32'h1);

        // Register access table
        for (int i = 0; i < 12; i++) begin
            wr_cs(reg_tab[i].cs, reg_tab[i].addr, reg_tab[i].wdata);
            rd_chk("reg_table", reg_tab[i].addr, reg_tab[i].mask, reg_tab[i].rexp);
        end

        // Scan and wrap
        wr(2'd0, 32'h0000_1234);
        for (int i = 0; i < 4; i++) begin
            wait_digit(i);
            chk("scan_segs", 32'(segs), 32'(scan_exp[i]));
        end
        wait_digit(0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("scan_seq", 32'(digit_en), 32'(1 << ((i / 4) % 4)));
        end

        // Decode sweep
        for (int i = 0; i < 16; i++) begin
            wr(2'd0, {28'h0, dec_tab[i].val});
            wait_digit(0);
            chk("decode_segs", 32'(segs), 32'(dec_tab[i].segs));
            chk("decode_dp", 32'(dp), 32'h1);
        end

        // Leading-zero suppression
        wr(2'd3, 32'h3);
        wr(2'd0, 32'h50);
        wait_digit(0); chk("lzs_d0", 32'(segs), 32'h40);
        wait_digit(1); chk("lzs_d1", 32'(segs), 32'h12);
        wait_digit(2); chk("lzs_d2", 32'(segs), 32'h7F);
        wait_digit(3); chk("lzs_d3", 32'(segs), 32'h7F);
        wr(2'd0, 32'h0);
        wait_digit(0); chk("lzs0_d0", 32'(segs), 32'h40);
        wait_digit(1); chk("lzs0_d1", 32'(segs), 32'h7F);
        wait_digit(2); chk("lzs0_d2", 32'(segs), 32'h7F);
        wait_digit(3); chk("lzs0_d3", 32'(segs), 32'h7F);

        // DP, BLANK and blink (from a fresh reset so the phase is known)
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wr(2'd0, 32'h1234);
        wr(2'd1, 32'h4);
        wr(2'd2, 32'h8);
        wr(2'd3, 32'h5);
        rd_chk("blink_phase_init", 2'd3, 32'h0001_0000, 32'h0);
        wait_digit(2);
        chk("dp_d2_segs", 32'(segs), 32'h24);
        chk("dp_d2_dp", 32'(dp), 32'h0);
        wait_digit(3);
        chk("blank_d3_segs", 32'(segs), 32'h7F);
        chk("blank_d3_dp", 32'(dp), 32'h1);
        address = 2'd3;
        found = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (readdata[16]) begin
                found = 1'b1;
                break;
            end
        end
        chk("blink_phase_on", 32'(found), 32'h1);
        for (k = 1; k <= 100; k++) begin
            tick();
            if (k >= 2 && k <= 17) begin
                chk("blink_dark_segs", 32'(segs), 32'h7F);
                chk("blink_dark_dp", 32'(dp), 32'h1);
                chk("blink_scanning", 32'(digit_en != 4'h0), 32'h1);
            end
            if (!readdata[16]) break;
        end
        chk("blink_period", 32'(k), 32'd64);
        wait_digit(2);
        chk("blink_visible_segs", 32'(segs), 32'h24);
        chk("blink_visible_dp", 32'(dp), 32'h0);

        // Disable and mid-scan reset
        wr(2'd3, 32'h0);
        tick();
        chk("dis_digit_en", 32'(digit_en), 32'h0);
        chk("dis_segs", 32'(segs), 32'h7F);
        chk("dis_dp", 32'(dp), 32'h1);
        address = 2'd3;
        #1;
        a0 = int'(readdata[10:8]);
        for (int i = 0; i < 4; i++) tick();
        chk("dis_idx_advance", 32'(readdata[10:8]), 32'((a0 + 1) % 4));
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (readdata[10:8] == 3'd2) begin
                found = 1'b1;
                break;
            end
        end
        chk("idx_reached_2", 32'(found), 32'h1);
        reset = 1'b1;
        tick();
        rd_chk("midrst_ctrl", 2'd3, 32'hFFFF_FFFF, 32'h1);
        rd_chk("midrst_data", 2'd0, 32'hFFFF_FFFF, 32'h0);
        reset = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            chipselect = ($urandom_range(0, 3) != 0);
            write = ($urandom_range(0, 2) == 0);
            address = 2'($urandom_range(0, 3));
            d = $urandom;
            for (int j = 0; j < 8; j++) if ($urandom_range(0, 1) == 0) d[4*j +: 4] = 4'h0;
            if (address == 2'd3 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
            writedata = d;
            tick();
            reset = 1'b0;
            chipselect = 1'b0;
            write = 1'b0;
            address = 2'($urandom_range(0, 3));
            #1;
            chk("model_readdata", readdata, m_read(address));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
